// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and frame constants for the FIFO-fed UART transmitter
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 10416;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_POP   = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - free-running bit-period counter with terminal-count pulse
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iClr,
  output logic oTick
);

  localparam int         W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] TC = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] r_cnt;

  assign oTick = (r_cnt == TC);

  always_ff @(posedge iClk) begin
    if (iRst || iClr) begin
      r_cnt <= '0;
    end else if (oTick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_fifo_tx.sv
// rtl/uart_fifo_tx.sv - pops bytes from a FIFO and sends them as 8N1 UART frames
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iEmpty,
  output logic       oRd,
  input  logic [7:0] iRdData,
  output logic       oTx,
  output logic       oBusy
);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_tx;
  logic       w_tick;
  logic       w_timer_clr;
  logic       w_last_bit;

  assign w_last_bit = (r_bit_cnt == 3'(DATA_BITS - 1));

  // The timer restarts on every state entry so each bit period is aligned to its state.
  assign w_timer_clr = (w_next != r_state) || (r_state == ST_IDLE) || (r_state == ST_POP);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .iClk (iClk),
    .iRst (iRst),
    .iClr (w_timer_clr),
    .oTick(w_tick)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (!iEmpty) w_next = ST_POP;
      ST_POP:   w_next = iEmpty ? ST_IDLE : ST_START;
      ST_START: if (w_tick) w_next = ST_DATA;
      ST_DATA:  if (w_tick && w_last_bit) w_next = ST_STOP;
      ST_STOP:  if (w_tick) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // oTx is loaded with the value of the upcoming bit at the same edge the state advances.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_tx      <= 1'b1;
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx      <= 1'b1;
          r_bit_cnt <= 3'd0;
        end
        ST_POP: begin
          if (!iEmpty) begin
            r_shift <= iRdData;
            r_tx    <= 1'b0;
          end else begin
            r_tx <= 1'b1;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_tx      <= r_shift[0];
            r_bit_cnt <= 3'd0;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (w_last_bit) begin
              r_tx <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end
        end
        ST_STOP: begin
          r_tx <= 1'b1;
        end
        default: begin
          r_tx <= 1'b1;
        end
      endcase
    end
  end

  assign oRd   = (r_state == ST_POP) && !iEmpty;
  assign oTx   = r_tx;
  assign oBusy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb/tb_uart_fifo_tx.sv - directed self-checking bench for uart_fifo_tx at 4 clocks per bit
module tb_uart_fifo_tx;

  localparam int CPB = 4;

  logic       iClk;
  logic       iRst;
  logic       iEmpty;
  logic       oRd;
  logic [7:0] iRdData;
  logic       oTx;
  logic       oBusy;

  int checks;
  int failures;

  logic rd_log [0:127];
  logic tx_log [0:127];

  uart_fifo_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iEmpty (iEmpty),
    .oRd    (oRd),
    .iRdData(iRdData),
    .oTx    (oTx),
    .oBusy  (oBusy)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic do_reset();
    iRst   = 1'b1;
    iEmpty = 1'b1;
    step();
    step();
    iRst = 1'b0;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[i-1];
  endfunction

  task automatic test_reset();
    iRst    = 1'b1;
    iEmpty  = 1'b0;
    iRdData = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      checks++;
      if ({oTx, oRd, oBusy} !== 3'b100) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: tx/rd/busy=%b%b%b expected 100", i, oTx, oRd, oBusy);
      end
      if (i < 2) step();
    end
    step();
    iRst = 1'b0;
    @(negedge iClk);
    checks++;
    if (oRd !== 1'b0 || oBusy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: rd=%b busy=%b expected 0 0", oRd, oBusy);
    end
    step();
    @(negedge iClk);
    checks++;
    if (oRd !== 1'b1 || oTx !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_pop: rd=%b tx=%b expected 1 1", oRd, oTx);
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] b;
    logic       exp;
    b = 8'hA5;
    do_reset();
    iRdData = b;
    iEmpty  = 1'b0;
    @(negedge iClk);
    checks++;
    if (oRd !== 1'b0) begin
      failures++;
      $display("FAIL single_idle_rd: rd=%b expected 0", oRd);
    end
    step();
    @(negedge iClk);
    checks++;
    if (oRd !== 1'b1 || oTx !== 1'b1 || oBusy !== 1'b1) begin
      failures++;
      $display("FAIL single_pop: rd/tx/busy=%b%b%b expected 111", oRd, oTx, oBusy);
    end
    step();
    iEmpty  = 1'b1;
    iRdData = 8'h00;
    for (int bit_i = 0; bit_i < 10; bit_i++) begin
      exp = frame_bit(b, bit_i);
      for (int k = 0; k < CPB; k++) begin
        @(negedge iClk);
        checks++;
        if (oTx !== exp || oRd !== 1'b0 || oBusy !== 1'b1) begin
          failures++;
          $display("FAIL single_frame bit %0d clk %0d: tx/rd/busy=%b%b%b expected %b01",
                   bit_i, k, oTx, oRd, oBusy, exp);
        end
        step();
      end
    end
    @(negedge iClk);
    checks++;
    if (oBusy !== 1'b0 || oTx !== 1'b1) begin
      failures++;
      $display("FAIL single_done: busy=%b tx=%b expected 0 1", oBusy, oTx);
    end
  endtask

  task automatic test_back_to_back();
    int pops;
    int p1;
    int p2;
    do_reset();
    pops    = 0;
    p1      = -1;
    p2      = -1;
    iRdData = 8'h00;
    iEmpty  = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge iClk);
      rd_log[n] = oRd;
      tx_log[n] = oTx;
      if (oRd === 1'b1) begin
        if (pops == 0) p1 = n;
        else if (pops == 1) p2 = n;
        pops++;
      end
      step();
      if (pops >= 1) iRdData = 8'hFF;
    end
    iEmpty = 1'b1;
    checks++;
    if (p1 != 1) begin
      failures++;
      $display("FAIL b2b_first_pop: cycle=%0d expected 1", p1);
    end
    checks++;
    if (p2 - p1 != 10 * CPB + 2) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d cycles expected %0d", p2 - p1, 10 * CPB + 2);
    end
    if (p1 == 1) begin
      for (int b = 0; b < 8; b++) begin
        checks++;
        if (tx_log[p1 + 1 + CPB + CPB * b + 2] !== 1'b0) begin
          failures++;
          $display("FAIL b2b_frame0 bit %0d: tx=%b expected 0", b, tx_log[p1 + 1 + CPB + CPB * b + 2]);
        end
      end
    end
    if (p2 > 0 && p2 < 50) begin
      checks++;
      if (tx_log[p2 + 2] !== 1'b0) begin
        failures++;
        $display("FAIL b2b_frame1_start: tx=%b expected 0", tx_log[p2 + 2]);
      end
      for (int b = 0; b < 8; b++) begin
        checks++;
        if (tx_log[p2 + 1 + CPB + CPB * b + 2] !== 1'b1) begin
          failures++;
          $display("FAIL b2b_frame1 bit %0d: tx=%b expected 1", b, tx_log[p2 + 1 + CPB + CPB * b + 2]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    iRdData = 8'h00;
    iEmpty  = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      step();
      if (c == 2) iRdData = 8'hFF;
    end
    @(negedge iClk);
    checks++;
    if (oTx !== 1'b0 || oBusy !== 1'b1) begin
      failures++;
      $display("FAIL mid_bit3: tx=%b busy=%b expected 0 1", oTx, oBusy);
    end
    iRst = 1'b1;
    step();
    @(negedge iClk);
    checks++;
    if ({oTx, oRd, oBusy} !== 3'b100) begin
      failures++;
      $display("FAIL mid_abort: tx/rd/busy=%b%b%b expected 100", oTx, oRd, oBusy);
    end
    step();
    @(negedge iClk);
    checks++;
    if (oRd !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_hold_rd: rd=%b expected 0", oRd);
    end
    iRst   = 1'b0;
    iEmpty = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      @(negedge iClk);
      checks++;
      if (oRd !== 1'b0 || oTx !== 1'b1) begin
        failures++;
        $display("FAIL mid_empty_wait cycle %0d: rd=%b tx=%b expected 0 1", c, oRd, oTx);
      end
    end
    step();
    iEmpty = 1'b0;
    @(negedge iClk);
    checks++;
    if (oRd !== 1'b0) begin
      failures++;
      $display("FAIL mid_resume_idle: rd=%b expected 0", oRd);
    end
    step();
    @(negedge iClk);
    checks++;
    if (oRd !== 1'b1) begin
      failures++;
      $display("FAIL mid_resume_pop: rd=%b expected 1", oRd);
    end
    iEmpty = 1'b1;
  endtask

  task automatic test_empty_race();
    do_reset();
    iRdData = 8'h5A;
    iEmpty  = 1'b0;
    step();
    iEmpty = 1'b1;
    @(negedge iClk);
    checks++;
    if ({oRd, oTx, oBusy} !== 3'b011) begin
      failures++;
      $display("FAIL race_pop: rd/tx/busy=%b%b%b expected 011", oRd, oTx, oBusy);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge iClk);
      checks++;
      if ({oRd, oTx, oBusy} !== 3'b010) begin
        failures++;
        $display("FAIL race_idle cycle %0d: rd/tx/busy=%b%b%b expected 010", c, oRd, oTx, oBusy);
      end
    end
  endtask

  task automatic test_idle();
    do_reset();
    iRdData = 8'hC3;
    for (int c = 0; c < 100; c++) begin
      @(negedge iClk);
      checks++;
      if (oRd !== 1'b0 || oTx !== 1'b1 || oBusy !== 1'b0) begin
        failures++;
        $display("FAIL idle cycle %0d: rd=%b tx=%b busy=%b expected 0 1 0", c, oRd, oTx, oBusy);
      end
      step();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    iRst     = 1'b1;
    iEmpty   = 1'b1;
    iRdData  = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_mid_reset();
    test_empty_race();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
